// File: rtl/pipe_stage_skid_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg_if
//   Beat bundle carried across a pipeline stage boundary (MEM->WB by default).
//
// Handshake: a beat moves exactly on a rising clk edge where valid && ready
//   are both 1. The master keeps valid and the payload stable until that
//   happens. ready may be asserted without valid.
//
// Parameters : DATA_W (alu_result / mem_read_value width), DEST_W (dest width)
// Signals    : valid, ready, wb_en, mem_r_en, alu_result, mem_read_value, dest
// Modports   : master drives valid + payload and samples ready;
//              slave samples valid + payload and drives ready.
// ---------------------------------------------------------------------------
interface pipe_stage_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
);
  logic              valid;
  logic              ready;
  logic              wb_en;
  logic              mem_r_en;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_read_value;
  logic [DEST_W-1:0] dest;

  modport master (
    output valid, wb_en, mem_r_en, alu_result, mem_read_value, dest,
    input  ready
  );

  modport slave (
    input  valid, wb_en, mem_r_en, alu_result, mem_read_value, dest,
    output ready
  );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//   Elastic pipeline stage register for the MEM->WB bundle, built on a
//   2-entry skid buffer (main + skid). Full throughput with a registered
//   upstream ready; synchronous flush; asynchronous active-high reset.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   flush      : synchronous kill of every held beat (also drops the beat
//                offered in the same cycle)
//   in_if      : upstream beat (slave modport; in_if.ready is registered)
//   out_if     : downstream beat (master modport; all fields register-driven,
//                wb_en / mem_r_en gated with valid)
//   stall_cnt  : cycles with out valid && !out ready && !flush, saturating
//
// Optional feature
//   PIPE_STAGE_STALL_CNT_EN : when defined, builds the stall counter;
//                             otherwise stall_cnt is tied to 0.
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_skid_reg_if.slave  in_if,
  pipe_stage_skid_reg_if.master out_if,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Beat layout: {wb_en, mem_r_en, alu_result, mem_read_value, dest}
  localparam int BEAT_W = 2 + 2 * DATA_W + DEST_W;

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q,   in_ready_d;
  logic [BEAT_W-1:0] main_q, main_d;
  logic [BEAT_W-1:0] skid_q, skid_d;
  logic [BEAT_W-1:0] in_beat;
  logic              up_acc;
  logic              main_load;

  assign in_beat = {in_if.wb_en, in_if.mem_r_en, in_if.alu_result,
                    in_if.mem_read_value, in_if.dest};

  // Upstream handshake uses the registered ready, so out_ready never
  // reaches in_ready combinationally.
  assign up_acc    = in_if.valid & in_ready_q;
  // Main can take a new beat when it is empty or its beat leaves this edge.
  assign main_load = ~main_valid_q | out_if.ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;

    if (main_load) begin
      if (skid_valid_q) begin
        // in_ready is 0 while skid holds a beat, so no upstream accept
        // can collide with this refill.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (up_acc) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (up_acc) begin
      // main is holding under backpressure: park the beat in skid.
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end

    // Flush wins over every accept; payload registers keep stale data.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_if.ready           = in_ready_q;
  assign out_if.valid          = main_valid_q;
  // Control bits are gated so an empty stage never requests a write-back.
  assign out_if.wb_en          = main_valid_q & main_q[BEAT_W-1];
  assign out_if.mem_r_en       = main_valid_q & main_q[BEAT_W-2];
  assign out_if.alu_result     = main_q[DEST_W + DATA_W +: DATA_W];
  assign out_if.mem_read_value = main_q[DEST_W +: DATA_W];
  assign out_if.dest           = main_q[DEST_W-1:0];

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    // Saturate at all-ones rather than wrap.
    if (main_valid_q && !out_if.ready && !flush && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 2 + 2 * DW + AW;

`ifdef PIPE_STAGE_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_skid_reg_if #(.DATA_W(DW), .DEST_W(AW)) in_if ();
  pipe_stage_skid_reg_if #(.DATA_W(DW), .DEST_W(AW)) out_if ();
  logic [31:0] stall_cnt;

  pipe_stage_skid_reg #(.DATA_W(DW), .DEST_W(AW), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_if     (in_if),
    .out_if    (out_if),
    .stall_cnt (stall_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  pipe_stage_skid_reg_if #(.DATA_W(DW), .DEST_W(AW)) in3_if ();
  pipe_stage_skid_reg_if #(.DATA_W(DW), .DEST_W(AW)) out3_if ();
  logic [2:0] stall_cnt3;

  assign in3_if.valid          = in_if.valid;
  assign in3_if.wb_en          = in_if.wb_en;
  assign in3_if.mem_r_en       = in_if.mem_r_en;
  assign in3_if.alu_result     = in_if.alu_result;
  assign in3_if.mem_read_value = in_if.mem_read_value;
  assign in3_if.dest           = in_if.dest;
  assign out3_if.ready         = out_if.ready;

  pipe_stage_skid_reg #(.DATA_W(DW), .DEST_W(AW), .CNT_W(3)) dut_c3 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_if     (in3_if),
    .out_if    (out3_if),
    .stall_cnt (stall_cnt3)
  );

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string tag, logic [BW-1:0] obs, logic [BW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  function automatic logic [BW-1:0] beat(logic wb, logic mr, logic [DW-1:0] alu,
                                         logic [DW-1:0] mrv, logic [AW-1:0] dst);
    return {wb, mr, alu, mrv, dst};
  endfunction

  // Output beats leave on the next rising edge; compare against the queue head.
  always @(negedge clk) begin
    if (!rst && out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {out_if.wb_en, out_if.mem_r_en, out_if.alu_result,
            out_if.mem_read_value, out_if.dest}, '0);
        if (n_err == 0) begin
          n_err++;
          $error("FAIL unexpected_beat observed=beat expected=none");
        end
      end else begin
        chk("out_beat", {out_if.wb_en, out_if.mem_r_en, out_if.alu_result,
            out_if.mem_read_value, out_if.dest}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [BW-1:0] b);
    in_if.valid          = 1'b1;
    in_if.wb_en          = b[BW-1];
    in_if.mem_r_en       = b[BW-2];
    in_if.alu_result     = b[AW + DW +: DW];
    in_if.mem_read_value = b[AW +: DW];
    in_if.dest           = b[AW-1:0];
  endtask

  task automatic idle();
    in_if.valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [BW-1:0] b, ba, bb, bc;

  initial begin
    in_if.valid = 1'b0;
    in_if.wb_en = 1'b0;
    in_if.mem_r_en = 1'b0;
    in_if.alu_result = '0;
    in_if.mem_read_value = '0;
    in_if.dest = '0;
    out_if.ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_in_ready", in_if.ready, 1);
    chk("rst_out_fields", {out_if.wb_en, out_if.mem_r_en, out_if.alu_result,
        out_if.mem_read_value, out_if.dest}, '0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", out_if.valid, 0);

    // Streaming at full throughput
    out_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = beat(i[0], i[1], 32'h10 + i, $urandom, AW'(i));
      drive(b);
      exp_q.push_back(b);
      tick();
      chk("stream_valid", out_if.valid, 1);
      chk("stream_alu", out_if.alu_result, 32'h10 + i);
      chk("stream_in_ready", in_if.ready, 1);
    end
    idle();
    tick();
    // Last streamed beat had wb_en=1 and mem_r_en=1; it is gone now.
    chk("drain_valid", out_if.valid, 0);
    chk("gated_wb_en", out_if.wb_en, 0);
    chk("gated_mem_r_en", out_if.mem_r_en, 0);

    // Backpressure fill
    out_if.ready = 1'b0;
    ba = beat(1'b1, 1'b0, 32'hAAAA0001, $urandom, 4'h1);
    bb = beat(1'b0, 1'b1, 32'hBBBB0002, $urandom, 4'h2);
    bc = beat(1'b1, 1'b1, 32'hCCCC0003, $urandom, 4'h3);
    drive(ba); exp_q.push_back(ba);
    tick();
    chk("bp_a_main", out_if.alu_result, 32'hAAAA0001);
    chk("bp_a_in_ready", in_if.ready, 1);
    drive(bb); exp_q.push_back(bb);
    tick();
    chk("bp_b_in_ready", in_if.ready, 0);
    chk("bp_b_main_holds", out_if.alu_result, 32'hAAAA0001);
    drive(bc);
    tick();
    chk("bp_c_in_ready", in_if.ready, 0);
    chk("bp_c_main_holds", out_if.alu_result, 32'hAAAA0001);
    repeat (3) tick();
    chk("stall_5", stall_cnt, CNT_EN ? 5 : 0);
    repeat (5) tick();
    chk("stall_10", stall_cnt, CNT_EN ? 10 : 0);
    chk("stall_sat_w3", stall_cnt3, CNT_EN ? 7 : 0);
    exp_q.push_back(bc);
    out_if.ready = 1'b1;
    tick();
    chk("bp_drain_b", out_if.alu_result, 32'hBBBB0002);
    chk("bp_drain_in_ready", in_if.ready, 1);
    tick();
    idle();
    chk("bp_drain_c", out_if.alu_result, 32'hCCCC0003);
    chk("bp_drain_c_valid", out_if.valid, 1);
    tick();
    chk("bp_empty", out_if.valid, 0);
    chk("stall_hold", stall_cnt, CNT_EN ? 10 : 0);

    // Flush with main + skid full and a beat offered
    out_if.ready = 1'b0;
    drive(beat(1'b1, 1'b0, 32'hD0D0D0D0, $urandom, 4'h4));
    tick();
    drive(beat(1'b1, 1'b0, 32'hE0E0E0E0, $urandom, 4'h5));
    tick();
    chk("fl_full_in_ready", in_if.ready, 0);
    drive(beat(1'b1, 1'b1, 32'hF0F0F0F0, $urandom, 4'h6));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl_out_valid", out_if.valid, 0);
    chk("fl_wb_en", out_if.wb_en, 0);
    chk("fl_in_ready", in_if.ready, 1);
    chk("fl_stall", stall_cnt, CNT_EN ? 11 : 0);
    // Flush while empty with in_ready=1: the offered beat must be dropped
    drive(beat(1'b1, 1'b1, 32'h60606060, $urandom, 4'h7));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl2_out_valid", out_if.valid, 0);
    out_if.ready = 1'b1;
    tick();
    chk("fl2_nothing", out_if.valid, 0);

    // Recovery after flush
    b = beat(1'b0, 1'b1, 32'h12345678, $urandom, 4'h8);
    drive(b); exp_q.push_back(b);
    tick();
    idle();
    chk("rec_valid", out_if.valid, 1);
    chk("rec_mem_r_en", out_if.mem_r_en, 1);
    tick();
    chk("rec_empty", out_if.valid, 0);

    // Async reset between edges
    out_if.ready = 1'b0;
    b = beat(1'b1, 1'b0, 32'h0BADF00D, $urandom, 4'hF);
    drive(b);
    tick();
    idle();
    chk("ar_pre_valid", out_if.valid, 1);
    chk("ar_pre_dest", out_if.dest, 4'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", out_if.valid, 0);
    chk("ar_dest", out_if.dest, 0);
    chk("ar_wb_en", out_if.wb_en, 0);
    chk("ar_in_ready", in_if.ready, 1);
    chk("ar_stall", stall_cnt, 0);
    tick();
    rst = 1'b0;
    out_if.ready = 1'b1;
    tick();
    tick();
    chk("ar_no_beat", out_if.valid, 0);
    chk("sb_empty", 70'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised pipeline stage register carrying the MEM->WB bundle: wb_en, mem_r_en, ALU result, memory read value and destination register.
- Replaces fixed-width freeze-only stage registers with a valid/ready elastic stage built on a 2-entry skid buffer (main + skid).
- Sustains full throughput with registered in_ready, and supports synchronous flush.
- Sits between MEM and WB; also reusable at any stage boundary by resizing the parameters.

Parameters:
DATA_W, 32, width of alu_result and mem_read_value fields
DEST_W, 4, width of destination register index
CNT_W, 32, width of stall counter (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous kill of all held beats
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat (registered)
in_wb_en  in  1  write-back enable
in_mem_r_en  in  1  memory-read (load) flag
in_alu_result  in  DATA_W  ALU result
in_mem_read_value  in  DATA_W  data memory read value
in_dest  in  DEST_W  destination register index
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_wb_en  out  1  wb_en of output beat, forced 0 when out_valid=0
out_mem_r_en  out  1  mem_r_en of output beat, forced 0 when out_valid=0
out_alu_result  out  DATA_W  ALU result of output beat
out_mem_read_value  out  DATA_W  read value of output beat
out_dest  out  DEST_W  destination of output beat
stall_cnt  out  CNT_W  backpressure cycle count (0 unless feature enabled)

Behaviour:
- Reset (async, rst=1): main_valid=0, skid_valid=0, all payload registers=0, stall_cnt=0; outputs: out_valid=0, in_ready=1, all out_* =0.
- Transfers: upstream accept = in_valid & in_ready; downstream accept = out_valid & out_ready.
- in_ready is a register equal to ~skid_valid; it never depends combinationally on out_ready.
- Latency: an accepted beat appears at the outputs on the next clk edge when main is empty or draining. Throughput is 1 beat/cycle under continuous out_ready=1.
- Main register update, when main empty or downstream accept:
  - skid_valid=1: main <= skid, skid_valid <= 0.
  - else, upstream accept: main <= input beat.
  - else: main_valid <= 0.
- Skid register update: main_valid=1 & out_ready=0 & upstream accept -> skid <= input beat, skid_valid <= 1.
- Full condition: main and skid both valid. Then in_ready=0 and no beat is lost. Beat order is strictly preserved.
- Empty condition: out_valid=0; out_wb_en and out_mem_r_en read 0. Payload fields hold stale data and must be ignored.
- Flush: at the next edge main_valid=0 and skid_valid=0, so in_ready=1 on the following cycle.
  - A beat offered in the flush cycle is dropped even if in_ready=1.
  - Flush overrides every simultaneous accept.
  - Payload registers are not cleared by flush.
- Reset asserted mid-transfer: all held beats are discarded immediately. No beat is emitted after rst deasserts until a new accept.
- No combinational path from in_* to out_*. All outputs are register-driven, except the out_valid gating AND on wb_en/mem_r_en.

Optional Feature:
- Macro PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with out_valid=1 & out_ready=0 & flush=0.
  - Saturates at all-ones and does not wrap.
  - Cleared only by rst.
- Undefined: no counter logic is built and stall_cnt is tied to 0.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 8 cycles with alu_result=0x10..0x17 -> out_valid from cycle 1; out_alu_result 0x10..0x17 in order, one per cycle; in_ready stays 1.
- Backpressure fill: beats A=0xAAAA0001, B=0xBBBB0002, C=0xCCCC0003 sent with out_ready=0 -> A in main, B in skid, in_ready=0 after B, C held upstream. Then out_ready=1 -> outputs A, B, C on consecutive cycles.
- Flush: two beats held (main+skid) with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, out_wb_en=0, in_ready=1; the flushed-cycle beat never appears.
- Async reset mid-operation: rst pulses between clk edges while out_valid=1, dest=0xF -> out_valid, out_dest, out_wb_en immediately 0; in_ready=1.
- Gated control: beat with wb_en=1, mem_r_en=1 drained, then no new input -> out_wb_en=0 and out_mem_r_en=0 while out_valid=0.
- Stall counter (macro defined): out_valid=1, out_ready=0 held for 5 cycles -> stall_cnt=5. With CNT_W=3 and held 10 cycles -> stall_cnt=7. Macro undefined -> stall_cnt=0.
